systolic_deskew_q: RTL
======================

// Module: systolic_deskew_q
// PURPOSE
//  Output-side counterpart of the input skew delay lines on the systolic array.
//  Column j of the array emits {enable,data} j cycles after column 0.
//  This block delays each column so all columns line up into one row vector.
//  Complete rows go into an output FIFO; a valid/ready port drains it toward the result writer.
// PARAMETERS
//  DATA_WIDTH  32  width of one column result
//  NUM_COLS    4   number of array columns (>=2)
//  OUT_DEPTH   8   row FIFO depth (power of 2, >=2)
// PORTS
//  clk            in   1                     rising-edge clock (single clock domain)
//  rst            in   1                     synchronous, active-high reset
//  col_en_in      in   NUM_COLS              per-column enable; bit j = column j
//  col_data_in    in   NUM_COLS*DATA_WIDTH   per-column data; slice j = [j*DW +: DW]
//  row_valid_out  out  1                     FIFO non-empty
//  row_ready_in   in   1                     consumer accepts the head row
//  row_data_out   out  NUM_COLS*DATA_WIDTH   head row, same column packing as input
//  fifo_count     out  $clog2(OUT_DEPTH)+1   rows held, 0..OUT_DEPTH
//  overflow       out  1                     sticky: a complete row was dropped
//  align_err      out  1                     sticky: mixed enables in an aligned vector
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - Clears all delay registers, FIFO pointers, fifo_count, overflow and align_err.
//   - Next cycle: row_valid_out=0, row_data_out=0, fifo_count=0.
//   - Rows in flight or queued are discarded.
//  Deskew:
//   - Column j passes through NUM_COLS-j registers, each holding {en,data}.
//   - Every delay register also clears on reset.
//   - Column 0 is sampled at edge t, column j at edge t+j.
//   - The aligned vector A sits in the last register of every column after edge t+NUM_COLS-1.
//  Row push decision (evaluated on A each cycle):
//   - All enables 1: push A into the FIFO at edge t+NUM_COLS.
//   - All enables 0: no action.
//   - Mixed enables: no push; align_err=1 from the next cycle until reset.
//  Latency: row_valid_out rises after edge t+NUM_COLS when the FIFO was empty.
//   - Sustained throughput is one row per clock.
//  FIFO: first-word-fall-through.
//   - row_data_out = head entry when non-empty, 0 when empty.
//   - Pop happens at an edge where row_valid_out=1 and row_ready_in=1.
//   - Pointers wrap modulo OUT_DEPTH.
//   - Push while full and no pop that cycle: row dropped, count unchanged, overflow=1 (sticky).
//   - Push while full with a pop that cycle: both happen, count stays OUT_DEPTH.
//   - Push into an empty FIFO has no same-cycle bypass; data is visible the cycle after the write.
//   - Pop while empty: ignored; row_ready_in is don't-care when row_valid_out=0.
//   - Push and pop in the same cycle: count unchanged.
//  fifo_count updates in the same cycle as each push or pop. The flags clear only on reset.
// TESTING (NUM_COLS=4, DATA_WIDTH=32, OUT_DEPTH=8)
//  1. Col j en=1, data=0x10+j at edge 10+j, ready=1
//     -> valid after edge 14; data {0x13,0x12,0x11,0x10}; popped at edge 15; count back to 0.
//  2. Ten skewed rows back-to-back, ready=1
//     -> valid for 10 consecutive cycles; rows emitted in order; overflow=0.
//  3. ready=0, nine rows pushed
//     -> count=8 after the 8th row; 9th row dropped; overflow=1; then ready=1 drains rows 1..8 exactly.
//  4. FIFO full; a pop and a push land on the same edge
//     -> count stays 8; new row accepted at the tail; overflow stays 0.
//  5. Column 2 enable skipped, others given correct skew
//     -> align_err=1; no push; later correct rows still pass.
//  6. rst=1 while 3 rows are queued and 2 are in flight
//     -> next cycle valid=0, count=0, flags=0; nothing emitted afterward.

Source files
------------

// File: rtl/systolic_deskew_q.sv
// Output deskew for the systolic array: column j is delayed NUM_COLS-j cycles so that
// all columns line up into one row, and complete rows are queued in a FWFT FIFO.
module systolic_deskew_q #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_COLS   = 4,
   parameter int OUT_DEPTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_COLS-1:0]            col_en_in,
   input  logic [NUM_COLS*DATA_WIDTH-1:0] col_data_in,
   output logic                           row_valid_out,
   input  logic                           row_ready_in,
   output logic [NUM_COLS*DATA_WIDTH-1:0] row_data_out,
   output logic [$clog2(OUT_DEPTH):0]     fifo_count,
   output logic                           overflow,
   output logic                           align_err
);

   localparam int PW = $clog2(OUT_DEPTH);
   localparam int RW = NUM_COLS * DATA_WIDTH;
   localparam logic [PW:0] C_FULL = (PW+1)'(OUT_DEPTH);

   logic [NUM_COLS-1:0] w_al_en;
   logic [RW-1:0]       w_al_data;

   for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
      localparam int DEPTH = NUM_COLS - j;
      logic [DEPTH-1:0]      r_en;
      logic [DATA_WIDTH-1:0] r_data [DEPTH];

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value, independent of statement order.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_en <= '0;
            for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
         end else begin
            r_en[0]   <= col_en_in[j];
            r_data[0] <= col_data_in[j*DATA_WIDTH +: DATA_WIDTH];
            for (int k = 1; k < DEPTH; k++) begin
               r_en[k]   <= r_en[k-1];
               r_data[k] <= r_data[k-1];
            end
         end
      end

      assign w_al_en[j]                           = r_en[DEPTH-1];
      assign w_al_data[j*DATA_WIDTH +: DATA_WIDTH] = r_data[DEPTH-1];
   end

   logic [RW-1:0] r_mem [OUT_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          r_overflow;
   logic          r_align_err;

   logic w_empty, w_full, w_row, w_mixed, w_pop, w_push, w_drop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FULL);
   assign w_row   = &w_al_en;
   assign w_mixed = |w_al_en && !w_row;
   assign w_pop   = !w_empty && row_ready_in;
   // A full FIFO still accepts a row when the head leaves on the same edge.
   assign w_push  = w_row && (!w_full || w_pop);
   assign w_drop  = w_row && w_full && !w_pop;

   // NOTE: the row storage has no reset; only pointers and count define which
   // entries are live, so clearing the array would add logic for no behaviour.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_al_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_align_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
         if (w_drop)  r_overflow  <= 1'b1;
         if (w_mixed) r_align_err <= 1'b1;
      end
   end

   assign row_valid_out = !w_empty;
   assign row_data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign fifo_count    = r_count;
   assign overflow      = r_overflow;
   assign align_err     = r_align_err;

endmodule
